// File: rtl/mips_icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The slave modport is the cache's view; the master modport is the core/memory environment's view.
interface mips_icache_if;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        icache_flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_ren, inst_addr, icache_flush, mem_ack, mem_rdata,
    output inst_data, inst_stall, mem_req, mem_addr
  );

  modport master (
    output inst_ren, inst_addr, icache_flush, mem_ack, mem_rdata,
    input  inst_data, inst_stall, mem_req, mem_addr
  );
endinterface

// File: rtl/mips_icache.sv
// Direct-mapped read-only I-cache: hits return in the fetch cycle, a miss stalls the core while one line
// is refilled word by word over mem_req/mem_ack. Define ICACHE_STAT_EN for saturating hit/miss counters.
module mips_icache #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic         clk,
  input  logic         rst,
  mips_icache_if.slave bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int LO_IDX = OFF_W + 2;
  localparam int TAG_W  = 32 - LO_IDX - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state_q, state_d;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES][LINE_WORDS];

  logic [31:LO_IDX] base_q;
  logic [OFF_W-1:0] cnt_q;
  logic             flush_pend_q;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             idle, lookup_hit, hit, miss, last_word, drop_fill;
  logic             stall, req;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^bus.inst_addr[1:0];

  assign req_off  = bus.inst_addr[LO_IDX-1:2];
  assign req_idx  = bus.inst_addr[LO_IDX+IDX_W-1:LO_IDX];
  assign req_tag  = bus.inst_addr[31:32-TAG_W];
  assign fill_idx = base_q[LO_IDX+IDX_W-1:LO_IDX];
  assign fill_tag = base_q[31:32-TAG_W];

  assign idle       = (state_q == IDLE);
  assign lookup_hit = bus.inst_ren & valid[req_idx] & (tags[req_idx] == req_tag);
  assign hit        = idle & lookup_hit;
  assign miss       = idle & bus.inst_ren & ~lookup_hit;
  assign last_word  = (cnt_q == OFF_W'(LINE_WORDS - 1));
  // A flush seen during DONE counts the same as one recorded earlier in the fill.
  assign drop_fill  = flush_pend_q | bus.icache_flush;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = miss;
        if (miss) state_d = FILL;
      end
      FILL: begin
        stall = 1'b1;
        req   = 1'b1;
        if (bus.mem_ack && last_word) state_d = DONE;
      end
      DONE: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.inst_stall = stall & ~rst;
  assign bus.inst_data  = (hit & ~rst) ? words[req_idx][req_off] : 32'd0;
  assign bus.mem_req    = req;
  assign bus.mem_addr   = {base_q, cnt_q, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      valid        <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (bus.icache_flush) valid <= '0;
          if (miss) begin
            base_q <= bus.inst_addr[31:LO_IDX];
            cnt_q  <= '0;
          end
        end
        FILL: begin
          if (bus.icache_flush) flush_pend_q <= 1'b1;
          if (bus.mem_ack) cnt_q <= cnt_q + OFF_W'(1);
        end
        DONE: begin
          if (drop_fill) valid <= '0;
          else           valid[fill_idx] <= 1'b1;
          flush_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (state_q == FILL && bus.mem_ack) words[fill_idx][cnt_q] <= bus.mem_rdata;
    if (state_q == DONE) tags[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && hit_cnt != 32'hFFFF_FFFF)   hit_cnt  <= hit_cnt + 32'd1;
      if (miss && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mips_icache.md
# mips_icache

Direct-mapped, read-only instruction cache between the 5-stage core's instruction-fetch port and the backing instruction memory. It serves hits combinationally in the same cycle as the fetch address and raises a stall to the pipeline on a miss. On a miss it refills one whole line through a word-serial request/acknowledge handshake.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per line; power of two, 2..16.
- LINES, 64: number of lines; power of two, 4..256.

Ports:
- clk  input  1  main clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- inst_ren  input  1  fetch request from core IF stage.
- inst_addr  input  32  fetch byte address; bits [1:0] ignored.
- inst_data  output  32  fetched instruction; valid when inst_ren=1 and inst_stall=0.
- inst_stall  output  1  miss in progress; core holds PC/IF while high.
- icache_flush  input  1  single-cycle pulse; invalidates all lines.
- mem_req  output  1  line-fill word request to backing memory.
- mem_addr  output  32  word address of current fill request; bits [1:0]=0.
- mem_ack  input  1  backing memory returns mem_rdata this cycle.
- mem_rdata  input  32  fill data, sampled when mem_req=1 and mem_ack=1.
- hit_cnt  output  32  hit counter; present only with ICACHE_STAT_EN.
- miss_cnt  output  32  miss counter; present only with ICACHE_STAT_EN.

## Operation
- Address split: offset = addr[log2(LINE_WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage per line: valid bit, tag, LINE_WORDS data words. All arrays are flops or LUT RAM with asynchronous read.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - hit = inst_ren & valid[index] & (tag match).
  - inst_data = word[index][offset] on hit, else 0.
  - inst_stall = inst_ren & ~hit.
  - On miss: latch line base address (offset zeroed), clear word counter, go to FILL.
- FILL:
  - mem_req=1; mem_addr = base + 4*counter; inst_stall=1.
  - Each cycle with mem_ack=1: write mem_rdata into word[counter]; counter+1; mem_addr advances the same edge.
  - After the ack for word LINE_WORDS-1, go to DONE.
  - mem_req stays high between words, including while mem_ack=0 (wait states unlimited).
- DONE:
  - mem_req=0, inst_stall=1.
  - Write tag, set valid (unless a flush is pending), return to IDLE.
  - Lookup re-evaluates in IDLE.
- mem_ack while mem_req=0 is ignored.
- Flush in IDLE: all valid bits clear at the next edge; a lookup in the same cycle still uses the old valid bits.
- Flush during FILL or DONE: recorded as pending; the fill completes, the line is not marked valid, all valid bits clear on DONE exit, pending clears.
- inst_addr changing during FILL/DONE: the fill completes for the latched line; the new address is looked up in IDLE.
- inst_ren=0 in IDLE: no lookup, inst_stall=0, no counter update.

## Timing
- Hit latency 0 cycles (combinational from inst_addr to inst_data/inst_stall).
- Miss, mem_ack tied high: miss cycle T, FILL T+1..T+LINE_WORDS, DONE T+LINE_WORDS+1, hit with inst_stall=0 at T+LINE_WORDS+2. Penalty is 6 cycles at LINE_WORDS=4.
- Each mem_ack wait cycle adds 1 cycle of penalty.
- Reset (asynchronous, any state including mid-fill): state=IDLE, all valid=0, counter=0, pending flush=0, mem_req=0, mem_addr=0. While rst=1: inst_stall=0, inst_data=0, and hit_cnt/miss_cnt=0.
- First fetch after reset always misses.

## Configuration
- ICACHE_STAT_EN defined:
  - hit_cnt increments each IDLE cycle with a hit.
  - miss_cnt increments once per IDLE→FILL transition.
  - Both saturate at 0xFFFFFFFF, clear on reset, and are not cleared by flush.
- ICACHE_STAT_EN undefined: hit_cnt/miss_cnt ports and counters are absent; all other behaviour is identical.

## Test plan
- Cold miss: reset, inst_ren=1, addr 0x00000010, mem_ack=1, mem_rdata=0xA0+word index -> mem_addr 0x10,0x14,0x18,0x1C on cycles 1-4; stall low on cycle 6; inst_data=0xA0.
- Same-line hits: after cold miss, addr 0x14/0x18/0x1C -> stall=0, data 0xA1/0xA2/0xA3 in the same cycle; no mem_req.
- Conflict: LINES=64, LINE_WORDS=4; fill 0x00000000, then fetch 0x00000400 (same index, new tag) -> miss, refill; then 0x00000000 misses again.
- Wait states: mem_ack low 2 cycles before each word -> mem_req held, mem_addr stable while waiting; stall released on cycle 14.
- Flush mid-fill: pulse icache_flush in FILL cycle 2 -> fill completes; the same address misses again in IDLE; previously valid lines also miss.
- Async reset mid-fill: assert rst during FILL word 2 -> mem_req=0 and mem_addr=0 immediately; the next fetch misses; with ICACHE_STAT_EN, miss_cnt reads 1 after the reset fill.
